driver_trace_buffer_reader: RTL and testbench

//  Read-side engine for the trace buffer BRAM port B. Accepts a read request (offset back

---
 rtl/driver_trace_buffer_reader.sv | 184 ++++++++++++++++++
 tb/tb_driver_trace_buffer_reader.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/driver_trace_buffer_reader.sv
// Port-B read engine for the circular trace buffer: credit-limited BRAM reads, latency
// absorption FIFO and valid/ready output stream. Optional macro: TRACE_RD_OVERRUN_CHECK_EN.
module driver_trace_buffer_reader #(
   parameter int unsigned TRACE_BUF_DATA_WIDTH = 256,
   parameter int unsigned TRACE_BUF_ADDR_WIDTH = 15,
   parameter int unsigned BRAM_RD_LATENCY      = 2,
   parameter int unsigned OUT_FIFO_DEPTH       = 4
) (
   input  logic                            clk,
   input  logic                            rstn,
   input  logic [TRACE_BUF_ADDR_WIDTH-1:0] wr_ptr,
   input  logic                            req_valid,
   output logic                            req_ready,
   input  logic [TRACE_BUF_ADDR_WIDTH-1:0] req_offset,
   input  logic [15:0]                     req_len,
   output logic [TRACE_BUF_ADDR_WIDTH-1:0] bram_addrb,
   output logic                            bram_enb,
   input  logic [TRACE_BUF_DATA_WIDTH-1:0] bram_doutb,
   output logic [TRACE_BUF_DATA_WIDTH-1:0] m_data,
   output logic                            m_valid,
   input  logic                            m_ready,
   output logic                            m_last,
   output logic                            busy,
   output logic                            done,
   output logic                            overrun
);

   localparam int unsigned DW  = TRACE_BUF_DATA_WIDTH;
   localparam int unsigned AW  = TRACE_BUF_ADDR_WIDTH;
   localparam int unsigned LAT = BRAM_RD_LATENCY;
   localparam int unsigned FD  = OUT_FIFO_DEPTH;
   localparam int unsigned PW  = $clog2(FD);
   localparam int unsigned CW  = PW + 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [AW-1:0] rd_addr_q, rd_addr_d;
   logic [15:0]   remaining_q, remaining_d;
   logic          done_q, done_d;

   logic [LAT-1:0] vld_sr_q;
   logic [LAT-1:0] last_sr_q;
   logic [CW-1:0]  inflight_q;
   logic [CW-1:0]  fifo_cnt_q;
   logic [PW-1:0]  fifo_wp_q;
   logic [PW-1:0]  fifo_rp_q;
   logic [DW-1:0]  fifo_data_q [FD];
   logic           fifo_last_q [FD];

   logic          req_acc;
   logic [CW:0]   credit_sum;
   logic          credit_ok;
   logic          issue;
   logic          issue_last;
   logic          push;
   logic          push_last;
   logic          pop;
   logic          head_last;

   assign req_acc    = req_valid && (state_q == S_IDLE);
   // Credit covers both words already queued and reads still inside the BRAM pipeline
   assign credit_sum = {1'b0, inflight_q} + {1'b0, fifo_cnt_q};
   assign credit_ok  = credit_sum < (CW + 1)'(FD);
   assign issue      = (state_q == S_ISSUE) && credit_ok;
   assign issue_last = issue && (remaining_q == 16'd1);
   assign push       = vld_sr_q[LAT-1];
   assign push_last  = last_sr_q[LAT-1];
   assign head_last  = fifo_last_q[fifo_rp_q];
   assign pop        = m_valid && m_ready;

   always_comb begin
      state_d     = state_q;
      rd_addr_d   = rd_addr_q;
      remaining_d = remaining_q;
      done_d      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_acc) begin
               rd_addr_d   = wr_ptr - req_offset;
               remaining_d = req_len;
               if (req_len == 16'd0) done_d  = 1'b1;
               else                  state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (issue) begin
               rd_addr_d   = rd_addr_q + AW'(1);
               remaining_d = remaining_q - 16'd1;
               if (issue_last) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (pop && head_last) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= S_IDLE;
         rd_addr_q   <= '0;
         remaining_q <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         rd_addr_q   <= rd_addr_d;
         remaining_q <= remaining_d;
         done_q      <= done_d;
      end
   end

   // Tag pipeline mirrors the BRAM read latency so data lands in the FIFO on its valid cycle
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         vld_sr_q   <= '0;
         last_sr_q  <= '0;
         inflight_q <= '0;
      end else begin
         vld_sr_q[0]  <= issue;
         last_sr_q[0] <= issue_last;
         for (int unsigned i = 1; i < LAT; i++) begin
            vld_sr_q[i]  <= vld_sr_q[i-1];
            last_sr_q[i] <= last_sr_q[i-1];
         end
         inflight_q <= inflight_q + CW'(issue) - CW'(push);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         fifo_cnt_q <= '0;
         fifo_wp_q  <= '0;
         fifo_rp_q  <= '0;
      end else begin
         fifo_cnt_q <= fifo_cnt_q + CW'(push) - CW'(pop);
         if (push) fifo_wp_q <= fifo_wp_q + PW'(1);
         if (pop)  fifo_rp_q <= fifo_rp_q + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data_q[fifo_wp_q] <= bram_doutb;
         fifo_last_q[fifo_wp_q] <= push_last;
      end
   end

   always_ff @(posedge clk) begin
      if (rstn && push) begin
         assert (fifo_cnt_q != CW'(FD));
      end
   end

`ifdef TRACE_RD_OVERRUN_CHECK_EN
   logic overrun_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)                             overrun_q <= 1'b0;
      else if (req_acc)                      overrun_q <= 1'b0;
      else if (issue && rd_addr_q == wr_ptr) overrun_q <= 1'b1;
   end

   assign overrun = overrun_q;
`else
   assign overrun = 1'b0;
`endif

   assign req_ready  = (state_q == S_IDLE);
   assign busy       = (state_q != S_IDLE);
   assign done       = done_q;
   assign bram_enb   = issue;
   assign bram_addrb = rd_addr_q;
   assign m_valid    = (fifo_cnt_q != '0);
   assign m_data     = fifo_data_q[fifo_rp_q];
   assign m_last     = m_valid && head_last;

endmodule

// File: tb/tb_driver_trace_buffer_reader.sv
// Directed bench for driver_trace_buffer_reader with a 2-cycle BRAM port-B model.
module tb_driver_trace_buffer_reader;

   localparam int DW = 256;
   localparam int AW = 15;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic [AW-1:0] wr_ptr = '0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [AW-1:0] req_offset = '0;
   logic [15:0]   req_len = '0;
   logic [AW-1:0] bram_addrb;
   logic          bram_enb;
   logic [DW-1:0] bram_doutb;
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic          m_ready = 1'b1;
   logic          m_last;
   logic          busy;
   logic          done;
   logic          overrun;

   driver_trace_buffer_reader #(
      .TRACE_BUF_DATA_WIDTH(256),
      .TRACE_BUF_ADDR_WIDTH(15),
      .BRAM_RD_LATENCY(2),
      .OUT_FIFO_DEPTH(4)
   ) dut (
      .clk(clk), .rstn(rstn), .wr_ptr(wr_ptr),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_offset(req_offset), .req_len(req_len),
      .bram_addrb(bram_addrb), .bram_enb(bram_enb), .bram_doutb(bram_doutb),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
      .busy(busy), .done(done), .overrun(overrun)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
      return {8{16'hA5C3, 1'b0, a}};
   endfunction

   // Port-B model: data appears two cycles after the enable cycle
   logic          p_vld = 1'b0;
   logic [AW-1:0] p_addr = '0;
   always @(posedge clk) begin
      p_vld      <= bram_enb;
      p_addr     <= bram_addrb;
      bram_doutb <= p_vld ? data_of(p_addr) : {8{32'hDEADBEEF}};
   end

   int tests = 0;
   int fails = 0;

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   int            cyc = 0;
   logic [AW-1:0] addr_q [$];
   logic [DW-1:0] data_q [$];
   logic          last_q [$];
   int enb_cnt = 0, valid_cnt = 0, busy_cnt = 0, done_cnt = 0, acc_cnt = 0, ovr_cnt = 0;
   int done_cyc = 0, acc_cyc = 0, last_pop = 0, first_valid = 0, first_enb = 0, last_enb = 0;
   int stab_err = 0;
   logic fv_pend = 1'b0, fe_pend = 1'b0, stall_prev = 1'b0, ovr_prev = 1'b0;
   logic [DW-1:0] data_prev = '0;
   logic [AW-1:0] prev_iss = '0, ovr_rise_addr = '0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (req_valid && req_ready) begin
         acc_cnt++;
         acc_cyc = cyc;
         fv_pend = 1'b1;
         fe_pend = 1'b1;
      end
      if (bram_enb) begin
         addr_q.push_back(bram_addrb);
         enb_cnt++;
         last_enb = cyc;
         if (fe_pend) begin
            first_enb = cyc;
            fe_pend = 1'b0;
         end
      end
      if (m_valid) begin
         valid_cnt++;
         if (fv_pend) begin
            first_valid = cyc;
            fv_pend = 1'b0;
         end
      end
      if (stall_prev && (!m_valid || m_data !== data_prev)) stab_err++;
      stall_prev = m_valid && !m_ready;
      data_prev  = m_data;
      if (m_valid && m_ready) begin
         data_q.push_back(m_data);
         last_q.push_back(m_last);
         last_pop = cyc;
      end
      if (busy) busy_cnt++;
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (overrun) ovr_cnt++;
      if (overrun && !ovr_prev) ovr_rise_addr = prev_iss;
      ovr_prev = overrun;
      if (bram_enb) prev_iss = bram_addrb;
   end

   int b_addr, b_data, b_enb, b_valid, b_busy, b_done, b_acc, b_ovr, b_stab;

   task automatic mark();
      b_addr = addr_q.size();  b_data = data_q.size();
      b_enb = enb_cnt;  b_valid = valid_cnt;  b_busy = busy_cnt;
      b_done = done_cnt;  b_acc = acc_cnt;  b_ovr = ovr_cnt;  b_stab = stab_err;
   endtask

   task automatic run_req(input logic [AW-1:0] wp, input logic [AW-1:0] off, input logic [15:0] len);
      @(posedge clk); #1;
      wr_ptr = wp; req_offset = off; req_len = len; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (done_cnt == b_done && n < 300) begin
         @(posedge clk);
         n++;
      end
      check({tag, "_done_seen"}, done_cnt != b_done, 1);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic check_stream(input string tag, input logic [AW-1:0] start, input int len);
      logic [AW-1:0] ea;
      check({tag, "_n_reads"}, addr_q.size() - b_addr, len);
      check({tag, "_n_beats"}, data_q.size() - b_data, len);
      for (int i = 0; i < len; i++) begin
         ea = start + AW'(i);
         if (b_addr + i < addr_q.size())
            check($sformatf("%s_addr%0d", tag, i), addr_q[b_addr + i], ea);
         if (b_data + i < data_q.size()) begin
            check($sformatf("%s_data%0d", tag, i), data_q[b_data + i], data_of(ea));
            check($sformatf("%s_last%0d", tag, i), last_q[b_data + i], i == len - 1);
         end
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_req_ready", req_ready, 1);
      check("rst_addrb", bram_addrb, 0);
      check("rst_enb", bram_enb, 0);
      check("rst_m_valid", m_valid, 0);
      check("rst_m_last", m_last, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_overrun", overrun, 0);
      rstn = 1'b1;

      // basic read, full-rate output
      mark();
      run_req(15'd100, 15'd10, 16'd4);
      wait_done("t1");
      check_stream("t1", 15'd90, 4);
      check("t1_done_cnt", done_cnt - b_done, 1);
      check("t1_done_lat", done_cyc - last_pop, 1);
      check("t1_first_lat", first_valid - acc_cyc, 4);
      check("t1_enb_span", last_enb - first_enb, 3);
      check("t1_busy", busy, 0);

      // start address wraps below zero
      mark();
      run_req(15'd2, 15'd5, 16'd6);
      wait_done("t2");
      check_stream("t2", 15'd32765, 6);

      // stalled consumer: credit limits issued reads to the FIFO depth
      m_ready = 1'b0;
      mark();
      run_req(15'd1000, 15'd300, 16'd16);
      repeat (20) @(posedge clk);
      #1;
      check("t3_stall_reads", enb_cnt - b_enb, 4);
      check("t3_stall_valid", m_valid, 1);
      check("t3_stall_beats", data_q.size() - b_data, 0);
      wr_ptr = 15'd5; req_offset = 15'd1; req_len = 16'd1; req_valid = 1'b1;
      check("t3_busy_ready", req_ready, 0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      m_ready = 1'b1;
      wait_done("t3");
      check_stream("t3", 15'd700, 16);
      check("t3_stable", stab_err - b_stab, 0);
      check("t3_accepts", acc_cnt - b_acc, 1);
      check("t3_done_cnt", done_cnt - b_done, 1);

      // zero-length request
      mark();
      run_req(15'd7, 15'd3, 16'd0);
      check("t4_ready", req_ready, 1);
      repeat (4) @(posedge clk);
      #1;
      check("t4_done_cnt", done_cnt - b_done, 1);
      check("t4_done_lat", done_cyc - acc_cyc, 1);
      check("t4_no_enb", enb_cnt - b_enb, 0);
      check("t4_no_valid", valid_cnt - b_valid, 0);
      check("t4_no_busy", busy_cnt - b_busy, 0);

      // reset in the middle of a request
      mark();
      run_req(15'd200, 15'd50, 16'd8);
      for (int n = 0; n < 100 && data_q.size() - b_data < 3; n++) @(posedge clk);
      #1;
      rstn = 1'b0;
      #1;
      check("t5_beats_before", data_q.size() - b_data, 3);
      for (int i = 0; i < 3; i++)
         if (b_data + i < data_q.size())
            check($sformatf("t5_pre_data%0d", i), data_q[b_data + i], data_of(15'd150 + AW'(i)));
      check("t5_rst_valid", m_valid, 0);
      check("t5_rst_last", m_last, 0);
      check("t5_rst_enb", bram_enb, 0);
      check("t5_rst_busy", busy, 0);
      check("t5_rst_addrb", bram_addrb, 0);
      check("t5_rst_ready", req_ready, 1);
      repeat (3) @(posedge clk);
      #1;
      rstn = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("t5_no_done", done_cnt - b_done, 0);
      check("t5_no_beats", data_q.size() - b_data, 3);
      mark();
      run_req(15'd10, 15'd3, 16'd2);
      wait_done("t5b");
      check_stream("t5b", 15'd7, 2);

      // reader reaches the live write pointer
      mark();
      run_req(15'd50, 15'd2, 16'd4);
      wait_done("t6");
      check_stream("t6", 15'd48, 4);
`ifdef TRACE_RD_OVERRUN_CHECK_EN
      check("t6_overrun", overrun, 1);
      check("t6_overrun_addr", ovr_rise_addr, 50);
`else
      check("t6_overrun", overrun, 0);
      check("t6_overrun_cycles", ovr_cnt - b_ovr, 0);
`endif
      run_req(15'd50, 15'd0, 16'd0);
      check("t6_overrun_clear", overrun, 0);
      repeat (3) @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1, "watchdog");
   end

endmodule
